// File: rtl/pulse_driver_pkg.sv
// Shared state encoding, default parameter values and sizing helpers
// for the pulse stretcher and its tick prescaler.
package pulse_driver_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int SAMPLE_COUNT_MAX_DEFAULT = 10;
  localparam int ON_TICKS_DEFAULT         = 20;
  localparam int GAP_TICKS_DEFAULT        = 20;
  localparam int PEND_MAX_DEFAULT         = 15;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold values 0..n, never less than one.
  function automatic int count_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pulse_driver_tick_gen.sv
// Free-running prescaler: counts 0..SAMPLE_COUNT_MAX and flags the
// terminal count with a one-cycle tick.
module sample_tick_gen
  import pulse_driver_pkg::*;
#(
  parameter int SAMPLE_COUNT_MAX = SAMPLE_COUNT_MAX_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int            CW   = count_width(SAMPLE_COUNT_MAX);
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_COUNT_MAX);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/pulse_driver.sv
// Request-queueing pulse stretcher: each accepted request produces a
// tick-timed high pulse followed by a mandatory low gap.
module pulse_driver
  import pulse_driver_pkg::*;
#(
  parameter int SAMPLE_COUNT_MAX = SAMPLE_COUNT_MAX_DEFAULT,
  parameter int ON_TICKS         = ON_TICKS_DEFAULT,
  parameter int GAP_TICKS        = GAP_TICKS_DEFAULT,
  parameter int PEND_MAX         = PEND_MAX_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pulse_in,
  output logic       level_out,
  output logic       busy,
  output logic [3:0] pend_count,
  output logic       overflow
);

  localparam int            TW         = count_width(max_int(ON_TICKS, GAP_TICKS));
  localparam logic [TW-1:0] ON_LAST    = TW'(ON_TICKS - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_TICKS - 1);
  localparam logic [3:0]    PEND_LIMIT = 4'(PEND_MAX);

  state_t        state, state_next;
  logic [TW-1:0] tick_cnt, tick_cnt_next;
  logic [3:0]    pend_next;
  logic          level_next, busy_next, overflow_next;
  logic          gap_exit;
  logic          tick;

  sample_tick_gen #(
    .SAMPLE_COUNT_MAX(SAMPLE_COUNT_MAX)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  // NOTE: every signal written here gets a default first, so no path
  // through the block can leave a value unassigned and infer a latch.
  always_comb begin
    state_next    = state;
    tick_cnt_next = tick_cnt;
    pend_next     = pend_count;
    overflow_next = 1'b0;
    gap_exit      = 1'b0;

    if (tick) tick_cnt_next = tick_cnt + 1'b1;

    case (state)
      IDLE: begin
        if (pulse_in) state_next = ON;
      end
      ON: begin
        if (tick && tick_cnt == ON_LAST) state_next = GAP;
      end
      GAP: begin
        if (tick && tick_cnt == GAP_LAST) begin
          gap_exit = 1'b1;
          // A request arriving on the exit tick is served directly, so the
          // queue only shrinks when nothing new arrives.
          if (pend_count != 4'd0 || pulse_in) state_next = ON;
          else                                state_next = IDLE;
          if (pend_count != 4'd0 && !pulse_in) pend_next = pend_count - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    if (state != IDLE && pulse_in && !gap_exit) begin
      if (pend_count == PEND_LIMIT) overflow_next = 1'b1;
      else                          pend_next     = pend_count + 1'b1;
    end

    if (state_next != state) tick_cnt_next = '0;

    // Outputs are decoded from the next state so they leave flops in step
    // with the state register.
    level_next = (state_next == ON);
    busy_next  = (state_next != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      pend_count <= '0;
      level_out  <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_next;
      tick_cnt   <= tick_cnt_next;
      pend_count <= pend_next;
      level_out  <= level_next;
      busy       <= busy_next;
      overflow   <= overflow_next;
    end
  end

endmodule

// File: tb/tb_pulse_driver.sv
// Scenario bench for pulse_driver with a small configuration; expected
// output pulses are queued as stimulus is driven and matched as they end.
module tb_pulse_driver;

  localparam int SCM  = 3;
  localparam int ONT  = 2;
  localparam int GAPT = 1;
  localparam int PM   = 3;

  typedef struct {
    int start;
    int width;
  } pulse_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pulse_in = 1'b0;
  logic       level_out, busy, overflow;
  logic [3:0] pend_count;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  pulse_t exp_q[$];
  pulse_t exp_p;
  logic   prev_level = 1'b0;
  int     rise_cyc = 0;

  pulse_driver #(
    .SAMPLE_COUNT_MAX(SCM),
    .ON_TICKS        (ONT),
    .GAP_TICKS       (GAPT),
    .PEND_MAX        (PM)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pulse_in  (pulse_in),
    .level_out (level_out),
    .busy      (busy),
    .pend_count(pend_count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard consumer: each completed level_out pulse is matched
  // against the oldest expectation.
  always @(negedge clk) begin
    if (level_out === 1'b1 && prev_level === 1'b0) rise_cyc = cyc;
    if (level_out === 1'b0 && prev_level === 1'b1) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL pulse_unexpected: got start=%0d width=%0d, expected no pulse",
                 rise_cyc, cyc - rise_cyc);
      end else begin
        exp_p = exp_q.pop_front();
        if (rise_cyc !== exp_p.start || (cyc - rise_cyc) !== exp_p.width) begin
          tests_failed++;
          $display("FAIL pulse_shape: got start=%0d width=%0d, expected start=%0d width=%0d",
                   rise_cyc, cyc - rise_cyc, exp_p.start, exp_p.width);
        end
      end
    end
    prev_level = level_out;
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    pulse_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    pulse_in = 1'b1;
    tests_run++;
    if ({level_out, busy, overflow, pend_count} !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got level=%b busy=%b ovf=%b pend=%0d, expected all 0",
               level_out, busy, overflow, pend_count);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pulse_in = 1'b0;
    repeat (10) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || level_out !== 1'b0 || pend_count !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_ignores_pulse: got busy=%b level=%b pend=%0d, expected 0 0 0",
               busy, level_out, pend_count);
    end
  endtask

  task automatic test_single();
    int t;
    do_reset();
    t = cyc;
    pulse_in = 1'b1;
    exp_q.push_back('{t + 1, 7});
    wait_until(t + 1);
    pulse_in = 1'b0;
    tests_run++;
    if (level_out !== 1'b1 || pend_count !== 4'd0) begin
      tests_failed++;
      $display("FAIL single_rise: got level=%b pend=%0d, expected 1 0", level_out, pend_count);
    end
    wait_until(t + 8);
    tests_run++;
    if (level_out !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_gap: got level=%b busy=%b, expected 0 1", level_out, busy);
    end
    wait_until(t + 11);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_busy_end: got busy=%b, expected 1", busy);
    end
    wait_until(t + 12);
    tests_run++;
    if (busy !== 1'b0 || pend_count !== 4'd0) begin
      tests_failed++;
      $display("FAIL single_idle: got busy=%b pend=%0d, expected 0 0", busy, pend_count);
    end
    wait_until(t + 20);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL single_drain: got %0d pulses outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int t;
    do_reset();
    t = cyc;
    pulse_in = 1'b1;
    exp_q.push_back('{t + 1, 7});
    exp_q.push_back('{t + 12, 8});
    exp_q.push_back('{t + 24, 8});
    for (int i = 1; i <= 3; i++) begin
      wait_until(t + i);
      if (i == 3) pulse_in = 1'b0;
      tests_run++;
      if (pend_count !== 4'(i - 1)) begin
        tests_failed++;
        $display("FAIL burst_pend_%0d: got %0d, expected %0d", i, pend_count, i - 1);
      end
    end
    wait_until(t + 12);
    tests_run++;
    if (pend_count !== 4'd1 || level_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL burst_dequeue: got pend=%0d level=%b, expected 1 1", pend_count, level_out);
    end
    wait_until(t + 36);
    tests_run++;
    if (busy !== 1'b0 || pend_count !== 4'd0) begin
      tests_failed++;
      $display("FAIL burst_idle: got busy=%b pend=%0d, expected 0 0", busy, pend_count);
    end
    wait_until(t + 45);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL burst_drain: got %0d pulses outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_overflow();
    int t;
    do_reset();
    t = cyc;
    pulse_in = 1'b1;
    exp_q.push_back('{t + 1, 7});
    exp_q.push_back('{t + 12, 8});
    exp_q.push_back('{t + 24, 8});
    exp_q.push_back('{t + 36, 8});
    wait_until(t + 1);
    pulse_in = 1'b0;
    wait_until(t + 2);
    pulse_in = 1'b1;
    wait_until(t + 5);
    tests_run++;
    if (pend_count !== 4'd3 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_saturate: got pend=%0d ovf=%b, expected 3 0", pend_count, overflow);
    end
    wait_until(t + 6);
    tests_run++;
    if (overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_fourth: got ovf=%b, expected 1", overflow);
    end
    wait_until(t + 7);
    pulse_in = 1'b0;
    tests_run++;
    if (overflow !== 1'b1 || pend_count !== 4'd3) begin
      tests_failed++;
      $display("FAIL ovf_fifth: got ovf=%b pend=%0d, expected 1 3", overflow, pend_count);
    end
    wait_until(t + 8);
    tests_run++;
    if (overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_clear: got ovf=%b, expected 0", overflow);
    end
    wait_until(t + 55);
    tests_run++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_drain: got %0d outstanding busy=%b, expected 0 0", exp_q.size(), busy);
    end
  endtask

  task automatic test_simultaneous();
    int t;
    do_reset();
    t = cyc;
    pulse_in = 1'b1;
    exp_q.push_back('{t + 1, 7});
    exp_q.push_back('{t + 12, 8});
    exp_q.push_back('{t + 24, 8});
    wait_until(t + 1);
    pulse_in = 1'b0;
    wait_until(t + 2);
    pulse_in = 1'b1;
    wait_until(t + 3);
    pulse_in = 1'b0;
    wait_until(t + 11);
    pulse_in = 1'b1;
    tests_run++;
    if (level_out !== 1'b0 || busy !== 1'b1 || pend_count !== 4'd1) begin
      tests_failed++;
      $display("FAIL simul_pre: got level=%b busy=%b pend=%0d, expected 0 1 1",
               level_out, busy, pend_count);
    end
    wait_until(t + 12);
    pulse_in = 1'b0;
    tests_run++;
    if (level_out !== 1'b1 || pend_count !== 4'd1) begin
      tests_failed++;
      $display("FAIL simul_exit: got level=%b pend=%0d, expected 1 1", level_out, pend_count);
    end
    wait_until(t + 24);
    tests_run++;
    if (level_out !== 1'b1 || pend_count !== 4'd0) begin
      tests_failed++;
      $display("FAIL simul_last: got level=%b pend=%0d, expected 1 0", level_out, pend_count);
    end
    wait_until(t + 45);
    tests_run++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL simul_drain: got %0d outstanding busy=%b, expected 0 0", exp_q.size(), busy);
    end
  endtask

  task automatic test_reset_mid_on();
    int t;
    do_reset();
    t = cyc;
    pulse_in = 1'b1;
    exp_q.push_back('{t + 1, 5});
    wait_until(t + 1);
    pulse_in = 1'b0;
    wait_until(t + 2);
    pulse_in = 1'b1;
    wait_until(t + 4);
    pulse_in = 1'b0;
    tests_run++;
    if (pend_count !== 4'd2 || level_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_setup: got pend=%0d level=%b, expected 2 1", pend_count, level_out);
    end
    wait_until(t + 5);
    #1 rst = 1'b1;
    #1;
    tests_run++;
    if (level_out !== 1'b0 || busy !== 1'b0 || pend_count !== 4'd0 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_async: got level=%b busy=%b pend=%0d ovf=%b, expected 0 0 0 0",
               level_out, busy, pend_count, overflow);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0 || busy !== 1'b0 || level_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_quiet: got %0d outstanding busy=%b level=%b, expected 0 0 0",
               exp_q.size(), busy, level_out);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_simultaneous();
    test_reset_mid_on();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
